logic_gate_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit with valid/ready streaming on both sides.

---
 rtl/logic_gate_pkg.sv | 25 ++
 rtl/logic_gate_pipe_if.sv | 28 ++
 rtl/logic_skid_buf.sv | 73 +++++++
 rtl/logic_gate_pipe.sv | 112 +++++++++++
 tb/tb_logic_gate_pipe.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/logic_gate_pkg.sv
// Shared types for the registered bitwise logic pipe: op codes and FSM states.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_ACC_AND = 3'd6,
    OP_ACC_OR  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // True for the two burst-folding ops.
  function automatic logic is_acc(op_e o);
    return (o == OP_ACC_AND) || (o == OP_ACC_OR);
  endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Streaming operand/result bundle for logic_gate_pipe.
interface logic_gate_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_any;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, a, b, op, in_last, out_ready,
    input  in_ready, out_valid, y, y_all, y_any, beat_cnt
  );

  modport slave (
    input  in_valid, a, b, op, in_last, out_ready,
    output in_ready, out_valid, y, y_all, y_any, beat_cnt
  );
endinterface

// File: rtl/logic_skid_buf.sv
// Two-entry output skid buffer: head register drives the outputs, spare absorbs one
// more beat under backpressure. in_ready is registered from the next occupancy.
module logic_skid_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          spare_v;
  logic [DW-1:0] spare_d;
  logic          head_v_n;
  logic [DW-1:0] head_d_n;
  logic          spare_v_n;
  logic [DW-1:0] spare_d_n;
  logic          ready_n;
  logic          push;
  logic          pop;

  // Next occupancy: head holds while stalled, otherwise refills from spare or input.
  always_comb begin
    head_v_n  = out_valid;
    head_d_n  = out_data;
    spare_v_n = spare_v;
    spare_d_n = spare_d;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    if (out_valid && !pop) begin
      if (push) begin
        spare_v_n = 1'b1;
        spare_d_n = in_data;
      end
    end else if (spare_v) begin
      head_v_n = 1'b1;
      head_d_n = spare_d;
      if (push) begin
        spare_d_n = in_data;
      end else begin
        spare_v_n = 1'b0;
      end
    end else if (push) begin
      head_v_n = 1'b1;
      head_d_n = in_data;
    end else begin
      head_v_n = 1'b0;
    end
    ready_n = !(head_v_n && spare_v_n);
  end

  // Buffer registers; reset clears contents and holds in_ready low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      spare_v   <= 1'b0;
      spare_d   <= '0;
      in_ready  <= 1'b0;
    end else begin
      out_valid <= head_v_n;
      out_data  <= head_d_n;
      spare_v   <= spare_v_n;
      spare_d   <= spare_d_n;
      in_ready  <= ready_n;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered WIDTH-bit logic unit with eight ops, burst accumulation and a skid output.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  logic_gate_pipe_if.slave bus
);

  localparam int unsigned DW = CNT_W + 2 + WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_e              cur_op;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] fold_cnt;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] res_cnt;
  logic             emit;
  logic             accept;
  logic             ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;

  // Op decode, accumulator fold, beat counting and IDLE/ACCUM next state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    res      = '0;
    res_cnt  = '0;
    accept   = bus.in_valid && ready;
    cur_op   = (state_q == ST_ACCUM) ? op_q : op_e'(bus.op);
    term     = (cur_op == OP_ACC_AND) ? (bus.a & bus.b) : (bus.a | bus.b);
    fold     = term;
    fold_cnt = CNT_W'(1);
    if (state_q == ST_ACCUM) begin
      fold     = (cur_op == OP_ACC_AND) ? (acc_q & term) : (acc_q | term);
      fold_cnt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : CNT_W'(cnt_q + CNT_W'(1));
    end
    if (accept) begin
      if (is_acc(cur_op)) begin
        acc_d = fold;
        cnt_d = fold_cnt;
        if (bus.in_last) begin
          emit    = 1'b1;
          res     = fold;
          res_cnt = fold_cnt;
          state_d = ST_IDLE;
        end else begin
          op_d    = cur_op;
          state_d = ST_ACCUM;
        end
      end else begin
        emit    = 1'b1;
        res_cnt = CNT_W'(1);
        case (cur_op)
          OP_AND:  res = bus.a & bus.b;
          OP_OR:   res = bus.a | bus.b;
          OP_XOR:  res = bus.a ^ bus.b;
          OP_NAND: res = ~(bus.a & bus.b);
          OP_NOR:  res = ~(bus.a | bus.b);
          OP_XNOR: res = ~(bus.a ^ bus.b);
          default: res = term;
        endcase
      end
    end
  end

  // FSM and accumulator state; reset discards any partial burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  logic_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (emit),
    .in_data   ({res_cnt, |res, &res, res}),
    .in_ready  (ready),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = out_data[WIDTH-1:0];
  assign bus.y_all     = out_data[WIDTH];
  assign bus.y_any     = out_data[WIDTH+1];
  assign bus.beat_cnt  = out_data[DW-1 -: CNT_W];

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: plain ops, bursts, backpressure, reset, saturation.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  logic_gate_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  logic_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Count one comparison and report it if the observed value differs.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one beat on bus8 at a negedge, wait for accept, return at the next negedge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input op_e op, input logic last);
    int n;
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    bus8.op       = op;
    bus8.in_last  = last;
    n = 0;
    while (!bus8.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send8_timeout", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  logic [7:0] plain_exp [6] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};
  logic [7:0] got_y [4];

  initial begin
    int idx;
    int got;
    int n;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.in_last = 1'b0;
    bus8.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.op = '0; bus2.in_last = 1'b0;
    bus2.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_y", 32'(bus8.y), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

    // Plain ops 0-5 on F0/3C.
    for (int i = 0; i < 6; i++) begin
      send8(8'hF0, 8'h3C, op_e'(3'(i)), 1'b0);
      chk($sformatf("plain%0d_valid", i), 32'(bus8.out_valid), 32'd1);
      chk($sformatf("plain%0d_y", i), 32'(bus8.y), 32'(plain_exp[i]));
      chk($sformatf("plain%0d_cnt", i), 32'(bus8.beat_cnt), 32'd1);
      chk($sformatf("plain%0d_any", i), 32'(bus8.y_any), 32'(|plain_exp[i]));
      chk($sformatf("plain%0d_all", i), 32'(bus8.y_all), 32'(&plain_exp[i]));
    end

    // ACC_AND burst of three beats.
    send8(8'hFF, 8'hF7, OP_ACC_AND, 1'b0);
    chk("accand_b1_nov", 32'(bus8.out_valid), 32'd0);
    send8(8'hFF, 8'h7F, OP_ACC_AND, 1'b0);
    chk("accand_b2_nov", 32'(bus8.out_valid), 32'd0);
    send8(8'hFE, 8'hFF, OP_ACC_AND, 1'b1);
    chk("accand_valid", 32'(bus8.out_valid), 32'd1);
    chk("accand_y", 32'(bus8.y), 32'h76);
    chk("accand_cnt", 32'(bus8.beat_cnt), 32'd3);
    chk("accand_any", 32'(bus8.y_any), 32'd1);
    chk("accand_all", 32'(bus8.y_all), 32'd0);

    // Backpressure: four AND beats with the consumer stalled, then released.
    @(negedge clk);
    bus8.out_ready = 1'b0;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && !(idx == 4 && got == 4); cyc++) begin
      logic acc_now;
      @(negedge clk);
      if (cyc == 4) begin
        chk("bp_accepted_before_release", 32'(idx), 32'd2);
        bus8.out_ready = 1'b1;
      end
      if (cyc == 2) chk("bp_ready_c2", 32'(bus8.in_ready), 32'd0);
      if (cyc == 3) chk("bp_ready_c3", 32'(bus8.in_ready), 32'd0);
      bus8.in_valid = (idx < 4);
      bus8.a        = 8'(idx + 1);
      bus8.b        = 8'hFF;
      bus8.op       = OP_AND;
      bus8.in_last  = 1'b0;
      acc_now = bus8.in_valid && bus8.in_ready;
      if (bus8.out_valid && bus8.out_ready) begin
        if (got < 4) got_y[got] = bus8.y;
        got++;
      end
      @(posedge clk);
      if (acc_now) idx++;
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_y%0d", i), 32'(got_y[i]), 32'(i + 1));
    @(negedge clk);
    chk("bp_no_dup", 32'(bus8.out_valid), 32'd0);

    // Mid-burst op change keeps the latched ACC_OR.
    send8(8'h01, 8'h00, OP_ACC_OR, 1'b0);
    send8(8'h00, 8'h02, OP_ACC_OR, 1'b0);
    send8(8'h04, 8'h00, OP_AND, 1'b1);
    chk("midop_valid", 32'(bus8.out_valid), 32'd1);
    chk("midop_y", 32'(bus8.y), 32'h07);
    chk("midop_cnt", 32'(bus8.beat_cnt), 32'd3);

    // Reset mid-burst with one result buffered.
    @(negedge clk);
    bus8.out_ready = 1'b0;
    send8(8'h5A, 8'hFF, OP_AND, 1'b0);
    send8(8'h0F, 8'h0F, OP_ACC_AND, 1'b0);
    send8(8'h0F, 8'h0F, OP_ACC_AND, 1'b0);
    chk("pre_rst_buffered", 32'(bus8.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("midrst_y", 32'(bus8.y), 32'd0);
    chk("midrst_cnt", 32'(bus8.beat_cnt), 32'd0);
    chk("midrst_in_ready", 32'(bus8.in_ready), 32'd0);
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready_after", 32'(bus8.in_ready), 32'd1);
    chk("midrst_no_partial", 32'(bus8.out_valid), 32'd0);
    send8(8'hAA, 8'hAA, OP_ACC_AND, 1'b1);
    chk("postrst_valid", 32'(bus8.out_valid), 32'd1);
    chk("postrst_y", 32'(bus8.y), 32'hAA);
    chk("postrst_cnt", 32'(bus8.beat_cnt), 32'd1);

    // CNT_W=2: five-beat ACC_OR burst saturates the counter at 3.
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.a        = 8'(1 << i);
      bus2.b        = 8'h00;
      bus2.op       = OP_ACC_OR;
      bus2.in_last  = (i == 4);
      n = 0;
      while (!bus2.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("send2_timeout", 32'(bus2.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus2.in_valid = 1'b0;
      if (i < 4) chk($sformatf("sat_b%0d_nov", i), 32'(bus2.out_valid), 32'd0);
    end
    chk("sat_valid", 32'(bus2.out_valid), 32'd1);
    chk("sat_y", 32'(bus2.y), 32'h1F);
    chk("sat_cnt", 32'(bus2.beat_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
